// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - IF-stage fetch PC, imem handshake, one-word buffer and branch redirect.
// Optional FETCH_STATS_EN adds fetch_count/flush_count statistics outputs.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_flush
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        consume;
    logic        redir;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    // A stalled ID stage may be reading a hazarded comparator result, so branches are gated.
    assign consume   = if_valid & ~stall;
    assign redir     = br_valid & br_taken & ~stall;
    assign if_flush  = redir;
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_nxt = redir ? FETCH : FULL;
                end else if (redir) begin
                    state_nxt = DROP;
                end
            end
            FULL:  if (consume) state_nxt = FETCH;
            DROP:  if (imem_ack) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if ((state == FETCH) || (state == DROP)) begin
            imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            tgt      <= 32'h0;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc4   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (redir) pc <= br_target;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redir) begin
                            pc <= br_target;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc4   <= pc_plus4;
                            if_valid <= 1'b1;
                            pc       <= pc_plus4;
                        end
                    end else if (redir) begin
                        tgt <= br_target;
                    end
                end
                FULL: begin
                    if (consume) begin
                        if_valid <= 1'b0;
                        if (redir) pc <= br_target;
                    end
                end
                DROP: begin
                    // The wrong-path word is thrown away; the most recent redirect wins.
                    if (redir) tgt <= br_target;
                    if (imem_ack) pc <= redir ? br_target : tgt;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
            flush_count <= 16'h0;
        end else begin
            if (consume) fetch_count <= fetch_count + 32'd1;
            if (redir)   flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed and randomized check of fetch_redirect_unit against a reference model.
module tb_fetch_redirect_unit;

    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_flush;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a fetch unit that is idle, waiting on a useful or useless fetch, or holding a word.
    bit          m_idle;
    bit          m_busy;
    bit          m_wrong;
    bit          m_full;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    int          m_fetches;
    int          m_flushes;

    fetch_redirect_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .if_flush(if_flush)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_idle = 1; m_busy = 0; m_wrong = 0; m_full = 0;
        m_pc = RPC; m_tgt = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_fetches = 0; m_flushes = 0;
    endtask

    // Called at a falling edge: check state, apply inputs, check flush, advance model, move to next falling edge.
    task automatic step(input bit s, input bit bv, input bit bt, input logic [31:0] t,
                        input bit a, input logic [31:0] d);
        bit r;
        bit c;
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_busy});
        chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_full});
        chk("if_instr", if_instr, m_instr);
        chk("if_pc4", if_pc4, m_pc4);
        stall = s; br_valid = bv; br_taken = bt; br_target = t; imem_ack = a; imem_rdata = d;
        #1;
        r = bv && bt && !s;
        c = m_full && !s;
        chk("if_flush", {31'h0, if_flush}, {31'h0, r});
        if (r) m_flushes++;
        if (c) m_fetches++;
        if (m_idle) begin
            if (r) m_pc = t;
            m_idle = 0; m_busy = 1;
        end else if (m_full) begin
            if (c) begin
                m_full = 0; m_busy = 1;
                if (r) m_pc = t;
            end
        end else if (m_busy && !m_wrong) begin
            if (a && r) m_pc = t;
            else if (a) begin
                m_instr = d; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                m_full = 1; m_busy = 0;
            end else if (r) begin
                m_tgt = t; m_wrong = 1;
            end
        end else if (m_wrong) begin
            if (r) m_tgt = t;
            if (a) begin
                m_pc = r ? t : m_tgt;
                m_wrong = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_addr", imem_addr, RPC);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        bit a;
        logic [31:0] t;
        rst = 1'b1; stall = 0; br_valid = 0; br_taken = 0; br_target = 0; imem_ack = 0; imem_rdata = 0;
        m_reset();
        @(negedge clk);
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_addr", imem_addr, RPC);
        chk("reset_valid", {31'h0, if_valid}, 32'h0);
        chk("reset_instr", if_instr, 32'h0);
        chk("reset_pc4", if_pc4, 32'h0);
        chk("reset_flush", {31'h0, if_flush}, 32'h0);
        rst = 1'b0;

        // Zero-wait memory: 40, 44, 48 two cycles apart.
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 32'hA000_0000 + i);
        chk("seq_pc4", if_pc4, 32'h0000_004C);

        // Hold a full buffer through a stall, with an ignored taken branch.
        guard = 0;
        while (!m_full && guard < 10) begin step(0, 0, 0, 0, 1, 32'hB000_0001); guard++; end
        chk("reach_full", {31'h0, m_full}, 32'h1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h0000_0900, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 0);

        // Redirect during a slow fetch, then the wrong-path ack.
        step(0, 1, 1, 32'h0000_0100, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk("drop_addr", imem_addr, 32'h0000_0100);
        step(0, 0, 0, 0, 1, 32'hC000_0100);

        // Redirect coinciding with an ack.
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0200, 1, 32'hBAD1_BAD1);
        chk("ackredir_addr", imem_addr, 32'h0000_0200);
        step(0, 0, 0, 0, 1, 32'hC000_0200);

        // PC wrap at the top of the address space.
        step(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 1, 32'hC000_FFFF);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", if_pc4, 32'h0000_0000);

        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 400) == 0) do_reset();
            a = m_busy && ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                 t, a, $urandom);
        end

`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, m_fetches);
        chk("flush_count", {16'h0, flush_count}, m_flushes & 32'h0000_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
